muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for EX-stage HI/LO arithmetic. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and owns the HI/LO registers.
//  Launches the external pipelined multiplier and iterative divider, and holds the pipeline via alu_stall until results commit.
//  Honours pipeline stall (no re-issue) and flush (abort, no commit).
// PARAMETERS
//  MUL_LATENCY  2   cycles from mul_start to valid mul_result (>=1)
//  DIV_MAX      34  watchdog: cycles in DIV_WAIT before forced abort
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-low
//  reg_stall   in   1   EX/MEM register held this cycle
//  reg_flush   in   1   EX contents being flushed this cycle
//  req_valid   in   1   EX holds an HI/LO op this cycle
//  req_op      in   3   muldiv_op_t: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  source_a    in   32  rs operand (forwarded)
//  source_b    in   32  rt operand (forwarded)
//  alu_stall   out  1   hold IF..EX; combinational
//  mul_start   out  1   1-cycle launch pulse; mul_sign/operands valid with it
//  div_start   out  1   1-cycle launch pulse; div_sign/operands valid with it
//  div_abort   out  1   1-cycle cancel pulse to divider
//  unit_sign   out  1   signed op (MULT/DIV)
//  unit_a      out  32  latched source_a
//  unit_b      out  32  latched source_b
//  mul_result  in   64  {hi,lo} product, valid MUL_LATENCY cycles after start
//  div_done    in   1   1-cycle pulse: quotient/remainder valid
//  div_quot    in   32  quotient -> LO
//  div_rem     in   32  remainder -> HI
//  hi          out  32  HI register
//  lo          out  32  LO register
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, unit_a/b=0, all pulses 0, alu_stall=0.
//  States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
//  IDLE, req_valid & !reg_flush:
//   MTHI/MTLO: write hi/lo <= source_a at edge; no stall; stay IDLE.
//   MULT(U): mul_start=1, latch operands, cnt<=MUL_LATENCY-1 -> MUL_WAIT.
//   DIV(U), source_b!=0: div_start=1, latch, wdog<=0 -> DIV_WAIT.
//   DIV(U), source_b==0: no launch, HI/LO unchanged, no stall -> DONE.
//  alu_stall = (IDLE & req_valid & op is MUL/DIV & !reg_flush) | MUL_WAIT | DIV_WAIT.
//  MUL_WAIT: cnt decrements; at cnt==0 {hi,lo}<=mul_result -> DONE.
//  DIV_WAIT: div_done -> hi<=div_rem, lo<=div_quot -> DONE.
//   wdog reaches DIV_MAX -> div_abort, no commit -> DONE.
//  DONE: alu_stall=0; request ignored (same instruction still in EX).
//   !reg_stall -> IDLE; reg_stall -> stay DONE, no relaunch.
//  reg_flush in MUL_WAIT/DIV_WAIT: -> IDLE, no commit; div_abort=1 if DIV_WAIT.
//   Flush wins over same-cycle completion.
//  reg_flush in DONE -> IDLE.
//  reg_flush with a request in IDLE: no launch, no write, even for MTHI/MTLO.
//  Late mul_result after flush is ignored: launch only from IDLE, capture only in MUL_WAIT.
//  Async reset mid-operation: immediate return to reset values; the external units must be reset by the same rst.
//  hi/lo are registered: a new value is visible the cycle after the commit edge.
// STRUCTURE
//  Package includes: muldiv_op_t (3-bit enum), mdc_state_t (2-bit enum), MDC_MUL_LATENCY and MDC_DIV_MAX defaults.
//  Single module, no sub-module. Multiplier and divider stay external units.
//  Counters: cnt $clog2(MUL_LATENCY+1) bits, wdog 6 bits.
// TESTING
//  MULT a=-3, b=7 -> stall MUL_LATENCY+1 cycles; hi=FFFFFFFF, lo=FFFFFFEB; single mul_start.
//  DIVU 100/7 with div_done after 33 cycles -> lo=14, hi=2; alu_stall low in DONE.
//  DIV by 0 with hi=5, lo=9 preset -> no div_start, no stall, hi/lo unchanged.
//  MULTU in DONE with reg_stall=1 for 3 cycles -> no second mul_start; IDLE after release.
//  reg_flush in DIV_WAIT coinciding with div_done -> div_abort=1, hi/lo unchanged, IDLE next cycle.
//  rst low mid-DIV_WAIT, then MTLO 0x1234 -> hi=lo=0 after reset; lo=0x1234 next edge, no stall.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and defaults for the EX-stage HI/LO sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } mdc_state_t;

  localparam int MDC_MUL_LATENCY = 2;
  localparam int MDC_DIV_MAX     = 34;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: launches the external multiplier/divider, stalls EX until
// the result commits, and honours pipeline stall and flush.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = MDC_MUL_LATENCY,
  parameter int DIV_MAX     = MDC_DIV_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_stall,
  input  logic        reg_flush,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] source_a,
  input  logic [31:0] source_b,
  output logic        alu_stall,
  output logic        mul_start,
  output logic        div_start,
  output logic        div_abort,
  output logic        unit_sign,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [63:0] mul_result,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  muldiv_op_t  op;
  mdc_state_t  state;
  mdc_state_t  state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [5:0]  wdog;
  logic [5:0]  wdog_next;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic [31:0] a_latch;
  logic [31:0] b_latch;
  logic        sign_latch;
  logic        launch;

  assign op     = muldiv_op_t'(req_op);
  assign launch = mul_start | div_start;

  // The units sample operands with the start pulse, so pass the live operands
  // through in the launch cycle and the latched copy afterwards.
  assign unit_a    = launch ? source_a : a_latch;
  assign unit_b    = launch ? source_b : b_latch;
  assign unit_sign = launch ? op_is_signed(op) : sign_latch;

  // State register, counters, HI/LO and operand latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= {CNT_W{1'b0}};
      wdog       <= 6'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      a_latch    <= 32'd0;
      b_latch    <= 32'd0;
      sign_latch <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      wdog  <= wdog_next;
      hi    <= hi_next;
      lo    <= lo_next;
      if (launch) begin
        a_latch    <= source_a;
        b_latch    <= source_b;
        sign_latch <= op_is_signed(op);
      end else begin
        a_latch    <= a_latch;
        b_latch    <= b_latch;
        sign_latch <= sign_latch;
      end
    end
  end

  // Next-state, commit and pulse decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wdog_next  = wdog;
    hi_next    = hi;
    lo_next    = lo;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    div_abort  = 1'b0;
    alu_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && !reg_flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_start  = 1'b1;
              alu_stall  = 1'b1;
              cnt_next   = CNT_W'(MUL_LATENCY - 1);
              state_next = ST_MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero skips the divider and leaves HI/LO untouched.
              if (source_b != 32'd0) begin
                div_start  = 1'b1;
                alu_stall  = 1'b1;
                wdog_next  = 6'd0;
                state_next = ST_DIV_WAIT;
              end else begin
                state_next = ST_DONE;
              end
            end
            OP_MTHI: hi_next = source_a;
            OP_MTLO: lo_next = source_a;
            default: state_next = ST_IDLE;
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        alu_stall = 1'b1;
        if (reg_flush) begin
          state_next = ST_IDLE;
        end else if (cnt == {CNT_W{1'b0}}) begin
          hi_next    = mul_result[63:32];
          lo_next    = mul_result[31:0];
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DIV_WAIT: begin
        alu_stall = 1'b1;
        if (reg_flush) begin
          div_abort  = 1'b1;
          state_next = ST_IDLE;
        end else if (div_done) begin
          hi_next    = div_rem;
          lo_next    = div_quot;
          state_next = ST_DONE;
        end else if (wdog == 6'(DIV_MAX)) begin
          div_abort  = 1'b1;
          state_next = ST_DONE;
        end else begin
          wdog_next = wdog + 6'd1;
        end
      end
      ST_DONE: begin
        // The finished instruction may still sit in EX; never relaunch it.
        if (reg_flush || !reg_stall) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected unit pulses and
// HI/LO commits; a monitor pops and compares whenever the DUT shows one.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_stall = 1'b0, reg_flush = 1'b0, req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] source_a = 32'd0, source_b = 32'd0;
  logic        alu_stall, mul_start, div_start, div_abort, unit_sign;
  logic [31:0] unit_a, unit_b, hi, lo;
  logic [63:0] mul_result;
  logic        div_done;
  logic [31:0] div_quot, div_rem;

  int tests = 0;
  int fails = 0;
  logic [67:0] pulse_q[$];
  logic [63:0] commit_q[$];

  muldiv_ctrl #(.MUL_LATENCY(2), .DIV_MAX(34)) dut (
    .clk(clk), .rst(rst), .reg_stall(reg_stall), .reg_flush(reg_flush),
    .req_valid(req_valid), .req_op(req_op), .source_a(source_a), .source_b(source_b),
    .alu_stall(alu_stall), .mul_start(mul_start), .div_start(div_start),
    .div_abort(div_abort), .unit_sign(unit_sign), .unit_a(unit_a), .unit_b(unit_b),
    .mul_result(mul_result), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Two-stage multiplier stand-in; output is garbage outside the valid cycle.
  logic        mv0, mv1;
  logic [63:0] mp0, mp1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv0 <= 1'b0; mv1 <= 1'b0; mp0 <= 64'd0; mp1 <= 64'd0;
    end else begin
      mv0 <= mul_start;
      mp0 <= unit_sign ? 64'($signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b}))
                       : {32'd0, unit_a} * {32'd0, unit_b};
      mv1 <= mv0;
      mp1 <= mp0;
    end
  end
  assign mul_result = mv1 ? mp1 : 64'hBADC_0FFE_BADC_0FFE;

  // Divider stand-in: div_done after div_delay cycles (0 = never).
  int          div_delay = 0;
  int          dcnt;
  logic [31:0] dq = 32'd0, dr = 32'd0;
  always @(posedge clk or negedge rst) begin
    if (!rst)           dcnt <= 0;
    else if (div_start) dcnt <= div_delay;
    else if (div_abort) dcnt <= 0;
    else if (dcnt > 0)  dcnt <= dcnt - 1;
  end
  assign div_done = (dcnt == 1);
  assign div_quot = div_done ? dq : 32'hDEAD_BEEF;
  assign div_rem  = div_done ? dr : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: every unit pulse and every HI/LO change must match the queue head.
  logic [63:0] prev_hilo;
  always @(negedge clk) begin
    if (!rst) begin
      prev_hilo = {hi, lo};
    end else begin
      if (mul_start || div_start || div_abort) begin
        if (pulse_q.size() == 0) check("unexpected_pulse", {mul_start, div_start, div_abort, unit_sign, unit_a, unit_b}, 68'd0);
        else check("pulse", {mul_start, div_start, div_abort, unit_sign, unit_a, unit_b}, pulse_q.pop_front());
      end
      if ({hi, lo} !== prev_hilo) begin
        if (commit_q.size() == 0) check("unexpected_commit", {4'd0, hi, lo}, {4'd0, prev_hilo});
        else check("commit", {4'd0, hi, lo}, {4'd0, commit_q.pop_front()});
        prev_hilo = {hi, lo};
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present one request, hold it while stalled, drop it after the free cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int stalls);
    req_valid = 1'b1; req_op = op; source_a = a; source_b = b; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!alu_stall) break;
      stalls++;
      cyc();
    end
    cyc();
    req_valid = 1'b0; req_op = OP_NONE;
  endtask

  int st;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hi, 68'd0);
    check("rst_lo", lo, 68'd0);
    check("rst_unit_a", unit_a, 68'd0);
    check("rst_outs", {alu_stall, mul_start, div_start, div_abort}, 68'd0);
    cyc(); rst = 1'b1; cyc();

    // MULT -3 * 7
    pulse_q.push_back({3'b100, 1'b1, 32'hFFFF_FFFD, 32'd7});
    commit_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, st);
    check("mult_stall", st, 68'd3);
    @(negedge clk);
    check("mult_hilo", {hi, lo}, {4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    cyc();

    // DIVU 100 / 7 with done after 33 cycles
    div_delay = 33; dq = 32'd14; dr = 32'd2;
    pulse_q.push_back({3'b010, 1'b0, 32'd100, 32'd7});
    commit_q.push_back({32'd2, 32'd14});
    run_op(OP_DIVU, 32'd100, 32'd7, st);
    check("divu_stall", st, 68'd34);
    @(negedge clk);
    check("divu_hilo", {hi, lo}, {4'd0, 32'd2, 32'd14});
    cyc();

    // Preset hi=5, lo=9, then divide by zero
    commit_q.push_back({32'd5, 32'd14});
    run_op(OP_MTHI, 32'd5, 32'd0, st);
    check("mthi_stall", st, 68'd0);
    commit_q.push_back({32'd5, 32'd9});
    run_op(OP_MTLO, 32'd9, 32'd0, st);
    run_op(OP_DIV, 32'd123, 32'd0, st);
    check("div0_stall", st, 68'd0);
    repeat (2) cyc();
    @(negedge clk);
    check("div0_hilo", {hi, lo}, {4'd0, 32'd5, 32'd9});
    cyc();

    // MULTU held in DONE by reg_stall: no second launch
    pulse_q.push_back({3'b100, 1'b0, 32'h0001_0000, 32'h0001_0000});
    commit_q.push_back({32'd1, 32'd0});
    reg_stall = 1'b1; req_valid = 1'b1; req_op = OP_MULTU;
    source_a = 32'h0001_0000; source_b = 32'h0001_0000;
    st = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!alu_stall) break;
      st++;
      cyc();
    end
    check("multu_stall", st, 68'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("done_held_nostall", alu_stall, 68'd0);
      cyc();
    end
    reg_stall = 1'b0;
    cyc();
    req_valid = 1'b0;
    commit_q.push_back({32'h0000_00A5, 32'd0});
    run_op(OP_MTHI, 32'h0000_00A5, 32'd0, st);
    @(negedge clk);
    check("after_release_hi", hi, 68'h0A5);
    cyc();

    // Flush with a request in IDLE: nothing happens
    reg_flush = 1'b1;
    run_op(OP_MTHI, 32'h0000_0999, 32'd0, st);
    run_op(OP_MULT, 32'd2, 32'd3, st);
    check("flush_idle_stall", st, 68'd0);
    reg_flush = 1'b0;

    // Flush in MUL_WAIT: no commit, late result ignored
    pulse_q.push_back({3'b100, 1'b1, 32'd2, 32'd3});
    req_valid = 1'b1; req_op = OP_MULT; source_a = 32'd2; source_b = 32'd3;
    cyc();
    reg_flush = 1'b1;
    cyc();
    reg_flush = 1'b0; req_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("mulflush_hilo", {hi, lo}, {4'd0, 32'h0000_00A5, 32'd0});
    cyc();

    // Flush in DIV_WAIT on the same cycle as div_done
    div_delay = 5; dq = 32'hFFFF_FFF0; dr = 32'hFFFF_FFFE;
    pulse_q.push_back({3'b010, 1'b1, 32'hFFFF_FFCE, 32'd3});
    pulse_q.push_back({3'b001, 1'b1, 32'hFFFF_FFCE, 32'd3});
    req_valid = 1'b1; req_op = OP_DIV; source_a = 32'hFFFF_FFCE; source_b = 32'd3;
    cyc();
    for (int i = 0; i < 20; i++) begin
      if (div_done) break;
      cyc();
    end
    reg_flush = 1'b1;
    @(negedge clk);
    check("flush_done_abort", {div_done, div_abort}, 68'd3);
    cyc();
    reg_flush = 1'b0; req_op = OP_MTLO; source_a = 32'h0000_0077;
    commit_q.push_back({32'h0000_00A5, 32'h0000_0077});
    @(negedge clk);
    check("after_flush_nostall", alu_stall, 68'd0);
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    check("after_flush_hilo", {hi, lo}, {4'd0, 32'h0000_00A5, 32'h0000_0077});
    cyc();

    // Watchdog: divider never answers
    div_delay = 0;
    pulse_q.push_back({3'b010, 1'b1, 32'd1, 32'd1});
    pulse_q.push_back({3'b001, 1'b1, 32'd1, 32'd1});
    run_op(OP_DIV, 32'd1, 32'd1, st);
    check("wdog_stall", st, 68'd36);
    @(negedge clk);
    check("wdog_hilo", {hi, lo}, {4'd0, 32'h0000_00A5, 32'h0000_0077});
    cyc();

    // Async reset mid-DIV_WAIT, then MTLO
    div_delay = 20;
    pulse_q.push_back({3'b010, 1'b0, 32'd1000, 32'd10});
    req_valid = 1'b1; req_op = OP_DIVU; source_a = 32'd1000; source_b = 32'd10;
    repeat (5) cyc();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("midrst_hilo", {hi, lo}, 68'd0);
    check("midrst_outs", {alu_stall, div_start, div_abort, unit_a}, 68'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    commit_q.push_back({32'd0, 32'h0000_1234});
    run_op(OP_MTLO, 32'h0000_1234, 32'd0, st);
    check("mtlo_stall", st, 68'd0);
    @(negedge clk);
    check("mtlo_hilo", {hi, lo}, {4'd0, 32'd0, 32'h0000_1234});
    repeat (3) cyc();

    check("pulse_q_empty", pulse_q.size(), 68'd0);
    check("commit_q_empty", commit_q.size(), 68'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
